// File: rtl/bias_leaky_act.sv
// Purpose: rescale conv accumulator beats, add bias, apply leaky ReLU, saturate, emit on valid/ready.
// Latency: 3 cycles from accepted beat to out_valid when out_ready stays high.
// Backpressure: a stalled output freezes all three stages and drops acc_ready; two dead cycles follow each acc_last.
// Ports: clk/rst_n (async, active-low); ap_done end-of-layer clear; leaky_en slope select;
//        acc_data/acc_valid/acc_last/acc_ready input beat; bias_data/bias_valid current bias;
//        cnn_conv_end one-cycle pulse per accepted last beat; out_data/out_valid/out_ready result.
module bias_leaky_act #(
  parameter int ACC_W  = 32,
  parameter int DATA_W = 16,
  parameter int SHIFT  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ap_done,
  input  logic              leaky_en,
  input  logic [ACC_W-1:0]  acc_data,
  input  logic              acc_valid,
  input  logic              acc_last,
  output logic              acc_ready,
  input  logic [DATA_W-1:0] bias_data,
  input  logic              bias_valid,
  output logic              cnn_conv_end,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  // S2 is wide enough to hold s1 * 13 without wrapping.
  localparam int EW = ACC_W + 5;

  localparam logic signed [ACC_W:0] RND      = (ACC_W+1)'(1) << (SHIFT - 1);
  localparam logic signed [EW-1:0]  LEAK_MUL = EW'(13);
  localparam logic signed [EW-1:0]  SAT_MAX  = {{(EW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EW-1:0]  SAT_MIN  = {{(EW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic                     adv;
  logic                     accept;
  logic [1:0]               guard;
  logic                     v1;
  logic                     v2;
  logic signed [ACC_W:0]    s1_q;
  logic signed [EW-1:0]     s2_q;

  logic signed [ACC_W:0]    acc_ext;
  logic signed [ACC_W:0]    bias_ext;
  logic signed [ACC_W:0]    r_val;
  logic signed [ACC_W:0]    s1_nxt;
  logic signed [EW-1:0]     s1_wide;
  logic signed [EW-1:0]     s2_nxt;
  logic [DATA_W-1:0]        sat_nxt;

  // The whole pipeline moves as one; it only holds when the output is stuck.
  assign adv       = !out_valid || out_ready;
  // guard keeps the next beat out until the bias controller has switched words.
  assign acc_ready = adv && bias_valid && (guard == 2'd0);
  assign accept    = acc_valid && acc_ready;

  always_comb begin
    acc_ext  = {acc_data[ACC_W-1], acc_data};
    bias_ext = {{(ACC_W+1-DATA_W){bias_data[DATA_W-1]}}, bias_data};
    // Extra headroom bit keeps the rounding add from overflowing at the top of range.
    r_val    = (acc_ext + RND) >>> SHIFT;
    s1_nxt   = r_val + bias_ext;

    s1_wide  = {{4{s1_q[ACC_W]}}, s1_q};
    // 13/128 approximates the 0.1 negative slope; the shift floors toward -inf.
    if (leaky_en && s1_q[ACC_W]) begin
      s2_nxt = (s1_wide * LEAK_MUL) >>> 7;
    end else begin
      s2_nxt = s1_wide;
    end

    if (s2_q > SAT_MAX) begin
      sat_nxt = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (s2_q < SAT_MIN) begin
      sat_nxt = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      sat_nxt = s2_q[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1           <= 1'b0;
      v2           <= 1'b0;
      out_valid    <= 1'b0;
      s1_q         <= '0;
      s2_q         <= '0;
      out_data     <= '0;
      guard        <= 2'd0;
      cnn_conv_end <= 1'b0;
    end else if (ap_done) begin
      // A beat accepted in this same cycle is intentionally dropped.
      v1           <= 1'b0;
      v2           <= 1'b0;
      out_valid    <= 1'b0;
      guard        <= 2'd0;
      cnn_conv_end <= 1'b0;
    end else begin
      cnn_conv_end <= accept && acc_last;
      if (accept && acc_last) begin
        guard <= 2'd2;
      end else if (guard != 2'd0) begin
        guard <= guard - 2'd1;
      end
      if (adv) begin
        v1        <= accept;
        s1_q      <= s1_nxt;
        v2        <= v1;
        s2_q      <= s2_nxt;
        out_valid <= v2;
        out_data  <= sat_nxt;
      end
    end
  end

endmodule

// File: tb/tb_bias_leaky_act.sv
// Purpose: randomized and directed checking of bias_leaky_act against an arithmetic reference.
// Latency: expects results three sampling cycles after acceptance with out_ready high.
// Backpressure: drives random out_ready and checks output stability while stalled.
module tb_bias_leaky_act;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ap_done = 1'b0;
  logic        leaky_en = 1'b1;
  logic [31:0] acc_data = '0;
  logic        acc_valid = 1'b0;
  logic        acc_last = 1'b0;
  logic        acc_ready;
  logic [15:0] bias_data = '0;
  logic        bias_valid = 1'b0;
  logic        cnn_conv_end;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;

  bias_leaky_act #(.ACC_W(32), .DATA_W(16), .SHIFT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ap_done      (ap_done),
    .leaky_en     (leaky_en),
    .acc_data     (acc_data),
    .acc_valid    (acc_valid),
    .acc_last     (acc_last),
    .acc_ready    (acc_ready),
    .bias_data    (bias_data),
    .bias_valid   (bias_valid),
    .cnn_conv_end (cnn_conv_end),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Floor division for a positive divisor.
  function automatic longint fdiv(input longint x, input longint d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic logic [15:0] ref_act(input logic [31:0] acc, input logic [15:0] bias,
                                          input logic leaky);
    longint s;
    s = fdiv(longint'($signed(acc)) + 128, 256) + longint'($signed(bias));
    if (leaky && s < 0) s = fdiv(s * 13, 128);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s);
  endfunction

  logic [15:0] exp_q[$];
  int          t_q[$];
  int          cyc_n = 0;
  int          since_last = 3;
  logic        exp_ce = 1'b0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic [15:0] last_out = '0;
  int          last_lat = 0;
  int          nouts = 0;
  logic        g_fire = 1'b0;
  logic        g_rdy = 1'b0;
  logic        g_ovld = 1'b0;

  // One cycle: inputs already driven at posedge+1; sample at the falling edge.
  task automatic tick();
    logic        acc_fire;
    logic        out_fire;
    logic [15:0] e;
    int          t;
    #4;
    acc_fire = acc_valid && acc_ready;
    out_fire = out_valid && out_ready;
    g_fire = acc_fire;
    g_rdy  = acc_ready;
    g_ovld = out_valid;
    chk("acc_ready", acc_ready, bias_valid && (!out_valid || out_ready) && (since_last >= 3));
    chk("conv_end", cnn_conv_end, exp_ce);
    if (prev_stall) begin
      chk("stall_vld", out_valid, 1);
      chk("stall_dat", out_data, prev_data);
    end
    if (out_fire) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out", out_valid, 0);
      end else begin
        e = exp_q.pop_front();
        t = t_q.pop_front();
        chk("out_data", out_data, e);
        last_out = out_data;
        last_lat = cyc_n - t;
        nouts++;
      end
    end
    if (ap_done) begin
      exp_q.delete();
      t_q.delete();
    end else if (acc_fire) begin
      exp_q.push_back(ref_act(acc_data, bias_data, leaky_en));
      t_q.push_back(cyc_n);
    end
    exp_ce = acc_fire && acc_last && !ap_done;
    if (ap_done) since_last = 3;
    else if (exp_ce) since_last = 1;
    else if (since_last < 3) since_last++;
    prev_stall = out_valid && !out_ready && !ap_done;
    prev_data  = out_data;
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string tag, input logic [31:0] a, input logic [15:0] b,
                          input logic lk, input logic [15:0] exp);
    int n0;
    leaky_en = lk; bias_data = b; bias_valid = 1'b1; out_ready = 1'b1;
    acc_data = a; acc_valid = 1'b1; acc_last = 1'b0;
    n0 = nouts;
    tick();
    acc_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk({tag, "_n"}, nouts - n0, 1);
    chk(tag, last_out, exp);
    chk({tag, "_lat"}, last_lat, 3);
  endtask

  initial begin
    int   n;
    int   budget;
    int   low;
    logic after4;
    logic [31:0] r;

    // Reset state
    #1;
    chk("rst_ovld", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ce", cnn_conv_end, 0);
    chk("rst_rdy", acc_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("nobias_rdy", g_rdy, 0);

    // Directed arithmetic
    directed("dir_pos",   32'h0001_2380, 16'h0010, 1'b1, 16'h0134);
    directed("dir_leaky", 32'hFFFF_9C00, 16'h0000, 1'b1, 16'hFFF5);
    directed("dir_lin",   32'hFFFF_9C00, 16'h0000, 1'b0, 16'hFF9C);
    directed("dir_satp",  32'h7FFF_FF00, 16'h7FFF, 1'b0, 16'h7FFF);
    directed("dir_satn",  32'h8000_0000, 16'h8000, 1'b0, 16'h8000);

    // Guard around acc_last: 8 beats, last on beat 4, new bias afterwards
    leaky_en = 1'b0; bias_data = 16'h0100; bias_valid = 1'b1; out_ready = 1'b1;
    n = 0; low = 0; after4 = 1'b0; budget = 0;
    while (n < 8 && budget < 100) begin
      acc_valid = 1'b1;
      acc_data  = $urandom_range(0, 32'h0010_0000);
      acc_last  = (n == 3);
      tick();
      budget++;
      if (g_fire) begin
        n++;
        if (n == 4) begin
          after4 = 1'b1;
          bias_data = 16'h0200;
        end else begin
          after4 = 1'b0;
        end
      end else if (after4) begin
        low++;
      end
    end
    acc_valid = 1'b0; acc_last = 1'b0;
    chk("guard_beats", n, 8);
    chk("guard_gap", low, 2);
    for (int i = 0; i < 5; i++) tick();

    // Random stimulus with 50% output backpressure, leaky then linear
    for (int ph = 0; ph < 2; ph++) begin
      leaky_en = (ph == 0);
      n = 0; budget = 0;
      while (n < 128 && budget < 5000) begin
        acc_valid = ($urandom_range(0, 9) < 8);
        r = $urandom;
        acc_data  = $urandom_range(0, 1) ? r : {{12{r[19]}}, r[19:0]};
        acc_last  = ($urandom_range(0, 9) == 0);
        bias_valid = ($urandom_range(0, 9) != 0);
        r = $urandom;
        bias_data = $urandom_range(0, 3) == 0 ? r[15:0] : {{8{r[7]}}, r[7:0]};
        out_ready = $urandom_range(0, 1);
        tick();
        budget++;
        if (g_fire) n++;
      end
      chk("rand_beats", n, 128);
      acc_valid = 1'b0; acc_last = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      chk("rand_drain", exp_q.size(), 0);
    end

    // ap_done with beats in flight, colliding with an acc_last accept
    leaky_en = 1'b1; bias_data = 16'h0005; bias_valid = 1'b1; out_ready = 1'b1;
    acc_valid = 1'b1; acc_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      acc_data = $urandom_range(0, 20000);
      tick();
    end
    acc_last = 1'b1; ap_done = 1'b1;
    tick();
    ap_done = 1'b0; acc_valid = 1'b0; acc_last = 1'b0;
    tick();
    chk("apdone_ovld", g_ovld, 0);
    chk("apdone_rdy", g_rdy, 1);
    directed("post_apdone", 32'h0001_2380, 16'h0010, 1'b1, 16'h0134);

    // Asynchronous reset mid-operation
    acc_valid = 1'b1; acc_data = 32'h0000_4000;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_ovld", g_ovld, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ovld", out_valid, 0);
    chk("mid_rst_ce", cnn_conv_end, 0);
    chk("mid_rst_data", out_data, 0);
    acc_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); t_q.delete();
    since_last = 3; exp_ce = 1'b0; prev_stall = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("post_rst_ovld", g_ovld, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bias_leaky_act.md
# bias_leaky_act

Post-convolution activation stage directly downstream of the bias controller. It consumes signed accumulator beats from the convolution array and the current `bias_data`/`bias_valid` word. Each beat is rescaled to the 16-bit feature-map format, the bias is added, leaky ReLU (slope ≈0.1) is applied when enabled, and the result is saturated and sent to the output writer over a valid/ready handshake. It also generates the `cnn_conv_end` pulse that advances the bias controller.

## Interface
- `ACC_W`, 32: accumulator width (signed).
- `DATA_W`, 16: bias and output width (signed fixed point).
- `SHIFT`, 8: arithmetic right shift from accumulator format to output format (≥1).
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ap_done` in 1: synchronous clear of pipeline and control state at end of layer.
- `leaky_en` in 1: 1 = leaky ReLU, 0 = linear (final detection layer). Must be quasi-static per layer.
- `acc_data` in ACC_W: signed conv accumulator.
- `acc_valid` in 1: accumulator beat valid.
- `acc_last` in 1: beat is the last of one conv pass (qualifies `acc_valid`).
- `acc_ready` out 1: beat accepted when `acc_valid && acc_ready`.
- `bias_data` in DATA_W: current bias from the bias controller.
- `bias_valid` in 1: `bias_data` usable.
- `cnn_conv_end` out 1: one-cycle pulse per accepted `acc_last` beat.
- `out_data` out DATA_W: activated, saturated result.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts when `out_valid && out_ready`.

## Operation
- Three-stage pipeline: S1, S2, S3. Each stage has a valid bit. Global advance `adv = !out_valid || out_ready`. All stages shift together on `adv`; bubbles propagate as invalid slots.
- `acc_ready = adv && bias_valid && (guard == 0)`. The bias is sampled in S1 on the accept cycle.
- S1: `r = (sext(acc_data) + 2^(SHIFT-1)) >>> SHIFT` (round half up). `s1 = r + sext(bias_data)`, held in ACC_W+1 bits.
- S2: if `leaky_en && s1 < 0`, then `s2 = (s1 * 13) >>> 7` (floor, slope 0.1016). Otherwise `s2 = s1`. Width ACC_W+5; no overflow possible.
- S3: saturate `s2` to `[-2^(DATA_W-1), 2^(DATA_W-1)-1]` and register it into `out_data`.
- Guard counter (2 bits):
  - Loads 2 in the cycle an `acc_last` beat is accepted; otherwise decrements to 0.
  - While nonzero, `acc_ready` = 0. This gives the bias controller's registered `w_cnt`/buffer switch time to present the next bias before the next beat is sampled.
- `cnn_conv_end` is registered: high exactly in the cycle after an `acc_last` beat is accepted, for one cycle. It is independent of output backpressure.
- `bias_valid` low: beats are not accepted (stall). The pipeline contents still drain on `adv`.
- `ap_done` (synchronous, priority over all else): clears all stage valids, `guard`, and `cnn_conv_end`. In-flight results are discarded. `out_data` may hold its value.

## Timing
- Reset (`rst_n` low, async): `out_valid`=0, `out_data`=0, `cnn_conv_end`=0, `guard`=0, stage valids 0. `acc_ready` is combinational and therefore 0 while `bias_valid`=0.
- Latency: a beat accepted at cycle T yields `out_valid` at T+3 when `out_ready` stays high.
- Throughput: 1 beat/cycle between `acc_last` boundaries. Each `acc_last` is followed by exactly 2 non-accept cycles.
- Backpressure: when `out_valid && !out_ready`, all stages freeze and `acc_ready`=0. `out_data` is stable until accepted. No beat is lost or duplicated.
- Simultaneous output handshake and input accept: both occur; the pipeline shifts by one.
- Simultaneous `ap_done` and accept: `ap_done` wins; the beat is dropped and no `cnn_conv_end` is generated.
- Reset mid-operation: all state returns to reset values immediately. No output pulse is produced.

## Test plan
- Positive path (leaky_en=1, bias=0x0010, acc=0x00012380, out_ready=1) → `out_data`=0x0134 at T+3, `out_valid` for 1 cycle.
- Leaky path (bias=0, acc=0xFFFF9C00, i.e. -100 after shift) → `out_data`=0xFFF5 (-11). Same beat with leaky_en=0 → 0xFF9C.
- Saturation (leaky_en=0, bias=0x7FFF, acc=0x7FFFFF00) → 0x7FFF. Acc=0x80000000, bias=0x8000 → 0x8000.
- Boundary guard: stream 8 beats with `acc_last` on beat 4 → `cnn_conv_end` high the cycle after beat 4 is accepted, `acc_ready` low for exactly 2 cycles, beats 5–8 use the new `bias_data`.
- Backpressure: random `out_ready` (50%) over 256 beats against a scoreboard → identical ordered results; `out_data` stable while stalled.
- `ap_done` with 3 beats in flight → `out_valid` 0 the next cycle, no `cnn_conv_end`. The following beat emerges normally at T+3.
